// File: rtl/sopc_mem_arbiter.sv
// Arbitrates the openmips fetch and data ports onto one synchronous memory.
// It runs one access at a time, with a fixed number of wait states and a stall request back to the core.
module sopc_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int DATA_FIRST  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_ce_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_data_o,
  output logic                if_ready_o,
  input  logic                d_ce_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_sel_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_data_i,
  output logic [DATA_W-1:0]   d_data_o,
  output logic                d_ready_o,
  output logic                stall_req_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_data_o,
  input  logic [DATA_W-1:0]   mem_data_i
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic       grant_d_reg;
  logic       pick_d;

  // Data port wins only when it is requesting and either has priority or fetch is idle.
  assign pick_d = (DATA_FIRST != 0) ? d_ce_i : (d_ce_i & ~if_ce_i);

  assign stall_req_o = (if_ce_i & ~if_ready_o) | (d_ce_i & ~d_ready_o);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      grant_d_reg <= 1'b0;
      if_data_o   <= '0;
      if_ready_o  <= 1'b0;
      d_data_o    <= '0;
      d_ready_o   <= 1'b0;
      mem_ce_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_sel_o   <= '0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if_ready_o <= 1'b0;
          d_ready_o  <= 1'b0;
          mem_ce_o   <= 1'b0;
          mem_we_o   <= 1'b0;
          if (if_ce_i | d_ce_i) begin
            grant_d_reg <= pick_d;
            mem_ce_o    <= 1'b1;
            cnt_reg     <= 4'(WAIT_CYCLES);
            state_reg   <= BUSY;
            if (pick_d) begin
              mem_we_o   <= d_we_i;
              mem_sel_o  <= d_sel_i;
              mem_addr_o <= d_addr_i;
              mem_data_o <= d_data_i;
            end else begin
              mem_we_o   <= 1'b0;
              mem_sel_o  <= '1;
              mem_addr_o <= if_addr_i;
              mem_data_o <= '0;
            end
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg - 4'd1;
          // Memory read data is only valid in the final enabled cycle.
          if (cnt_reg == 4'd1) begin
            mem_ce_o  <= 1'b0;
            mem_we_o  <= 1'b0;
            state_reg <= RESP;
            if (grant_d_reg) begin
              d_ready_o <= 1'b1;
              if (!mem_we_o) d_data_o <= mem_data_i;
            end else begin
              if_ready_o <= 1'b1;
              if_data_o  <= mem_data_i;
            end
          end
        end
        RESP: begin
          if_ready_o <= 1'b0;
          d_ready_o  <= 1'b0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Directed bench for sopc_mem_arbiter: three instances cover the
// wait-state and priority configurations, each driven independently.
module tb_sopc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce    [3];
  logic [31:0] if_addr  [3];
  logic [31:0] if_data  [3];
  logic        if_ready [3];
  logic        d_ce     [3];
  logic        d_we     [3];
  logic [3:0]  d_sel    [3];
  logic [31:0] d_addr   [3];
  logic [31:0] d_wdata  [3];
  logic [31:0] d_data   [3];
  logic        d_ready  [3];
  logic        stall    [3];
  logic        mem_ce   [3];
  logic        mem_we   [3];
  logic [3:0]  mem_sel  [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata[3];
  logic [31:0] mem_rdata[3];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h4) return 32'h34011100;
    return {a[15:0], 16'hC0DE};
  endfunction

  // Instance 0: WAIT=2 data-first; 1: WAIT=1 data-first; 2: WAIT=1 fetch-first.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    assign mem_rdata[gi] = mem_model(mem_addr[gi]);
    sopc_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32),
      .WAIT_CYCLES(gi == 0 ? 2 : 1),
      .DATA_FIRST(gi == 2 ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .if_ce_i(if_ce[gi]), .if_addr_i(if_addr[gi]),
      .if_data_o(if_data[gi]), .if_ready_o(if_ready[gi]),
      .d_ce_i(d_ce[gi]), .d_we_i(d_we[gi]), .d_sel_i(d_sel[gi]),
      .d_addr_i(d_addr[gi]), .d_data_i(d_wdata[gi]),
      .d_data_o(d_data[gi]), .d_ready_o(d_ready[gi]),
      .stall_req_o(stall[gi]),
      .mem_ce_o(mem_ce[gi]), .mem_we_o(mem_we[gi]), .mem_sel_o(mem_sel[gi]),
      .mem_addr_o(mem_addr[gi]), .mem_data_o(mem_wdata[gi]),
      .mem_data_i(mem_rdata[gi])
    );
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] vec(input int i);
    return {mem_ce[i], mem_we[i], if_ready[i], d_ready[i], stall[i]};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_ce[i] = 0; if_addr[i] = '0; d_ce[i] = 0; d_we[i] = 0;
      d_sel[i] = '0; d_addr[i] = '0; d_wdata[i] = '0;
    end
    #2;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({vec(i), mem_addr[i], if_data[i], d_data[i]} !== '0)
        $display("FAIL reset[%0d]: got vec=%b addr=%h if_data=%h d_data=%h, want all 0",
                 i, vec(i), mem_addr[i], if_data[i], d_data[i]);
      else pass_cnt++;
    end
    tick; tick;
    rst = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_fetch;
    logic [4:0] exp_v [4] = '{5'b10001, 5'b10001, 5'b00100, 5'b00000};
    if_ce[0] = 1; if_addr[0] = 32'h4;
    for (int c = 0; c < 4; c++) begin
      tick;
      total_cnt++;
      if (vec(0) !== exp_v[c] || (c < 2 && mem_addr[0] !== 32'h4))
        $display("FAIL fetch c%0d: got vec=%b addr=%h, want vec=%b addr=4", c + 1, vec(0), mem_addr[0], exp_v[c]);
      else pass_cnt++;
      if (c == 2) if_ce[0] = 0;
      if (c >= 2) begin
        total_cnt++;
        if (if_data[0] !== 32'h34011100)
          $display("FAIL fetch_data c%0d: got %h want 34011100", c + 1, if_data[0]);
        else pass_cnt++;
      end
    end
    $display("fetch: addr=4 data=%h", if_data[0]);
  endtask

  // Both ports request together on instance i; first_d selects which is served first.
  task automatic test_priority(input int i, input logic first_d, input logic [4:0] exp_v [6]);
    logic [31:0] first_a, second_a;
    if_ce[i] = 1; if_addr[i] = 32'h8;
    d_ce[i] = 1; d_we[i] = 0; d_sel[i] = 4'hF; d_addr[i] = 32'h20;
    first_a  = first_d ? 32'h20 : 32'h8;
    second_a = first_d ? 32'h8 : 32'h20;
    for (int c = 1; c <= 6; c++) begin
      tick;
      total_cnt++;
      if (vec(i) !== exp_v[c-1])
        $display("FAIL priority[%0d] c%0d: got vec=%b want %b", i, c, vec(i), exp_v[c-1]);
      else pass_cnt++;
      if (c == 1 || c == 4) begin
        total_cnt++;
        if (mem_addr[i] !== (c == 1 ? first_a : second_a))
          $display("FAIL priority_addr[%0d] c%0d: got %h want %h", i, c, mem_addr[i], (c == 1 ? first_a : second_a));
        else pass_cnt++;
      end
      if (c == 2) begin
        if (first_d) d_ce[i] = 0; else if_ce[i] = 0;
      end
      if (c == 5) begin
        if (first_d) if_ce[i] = 0; else d_ce[i] = 0;
      end
    end
    total_cnt++;
    if (if_data[i] !== mem_model(32'h8) || d_data[i] !== mem_model(32'h20))
      $display("FAIL priority_data[%0d]: got if=%h d=%h want if=%h d=%h",
               i, if_data[i], d_data[i], mem_model(32'h8), mem_model(32'h20));
    else pass_cnt++;
    $display("priority[%0d]: first_d=%0d if_data=%h d_data=%h", i, first_d, if_data[i], d_data[i]);
  endtask

  task automatic test_write;
    d_ce[0] = 1; d_we[0] = 0; d_sel[0] = 4'hF; d_addr[0] = 32'h40;
    tick; tick; tick;
    total_cnt++;
    if (vec(0) !== 5'b00010 || d_data[0] !== 32'h0040C0DE)
      $display("FAIL read40: got vec=%b d_data=%h want 00010 0040c0de", vec(0), d_data[0]);
    else pass_cnt++;
    d_ce[0] = 0;
    tick;
    $display("read: addr=40 data=%h", d_data[0]);
    d_ce[0] = 1; d_we[0] = 1; d_sel[0] = 4'b0011; d_addr[0] = 32'h100; d_wdata[0] = 32'hDEADBEEF;
    for (int c = 1; c <= 2; c++) begin
      tick;
      total_cnt++;
      if (vec(0) !== 5'b11001 || mem_sel[0] !== 4'b0011 || mem_wdata[0] !== 32'hDEADBEEF || mem_addr[0] !== 32'h100)
        $display("FAIL write c%0d: got vec=%b sel=%b data=%h addr=%h want 11001 0011 deadbeef 100",
                 c, vec(0), mem_sel[0], mem_wdata[0], mem_addr[0]);
      else pass_cnt++;
    end
    tick;
    total_cnt++;
    if (vec(0) !== 5'b00010 || d_data[0] !== 32'h0040C0DE)
      $display("FAIL write_done: got vec=%b d_data=%h want 00010 0040c0de", vec(0), d_data[0]);
    else pass_cnt++;
    d_ce[0] = 0; d_we[0] = 0;
    tick;
    total_cnt++;
    if (vec(0) !== 5'b00000)
      $display("FAIL write_idle: got vec=%b want 00000", vec(0));
    else pass_cnt++;
    $display("write: addr=100 data=deadbeef sel=0011");
  endtask

  task automatic test_flush;
    if_ce[0] = 1; if_addr[0] = 32'hC;
    tick;
    if_ce[0] = 0;
    tick;
    total_cnt++;
    if (vec(0) !== 5'b10000)
      $display("FAIL flush_busy: got vec=%b want 10000", vec(0));
    else pass_cnt++;
    tick;
    total_cnt++;
    if (vec(0) !== 5'b00100 || if_data[0] !== 32'h000CC0DE)
      $display("FAIL flush_ready: got vec=%b data=%h want 00100 000cc0de", vec(0), if_data[0]);
    else pass_cnt++;
    tick;
    $display("flush: addr=c data=%h", if_data[0]);
  endtask

  task automatic test_reset_mid_busy;
    if_ce[0] = 1; if_addr[0] = 32'h10;
    tick;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({vec(0), mem_addr[0], if_data[0], d_data[0]} !== {5'b00001, 96'h0})
      $display("FAIL async_reset: got vec=%b addr=%h if=%h d=%h want 00001 0 0 0",
               vec(0), mem_addr[0], if_data[0], d_data[0]);
    else pass_cnt++;
    if_ce[0] = 0;
    tick;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      total_cnt++;
      if (vec(0) !== 5'b00000)
        $display("FAIL reset_no_ready c%0d: got vec=%b want 00000", c, vec(0));
      else pass_cnt++;
    end
    if_ce[0] = 1; if_addr[0] = 32'h4;
    tick; tick; tick;
    total_cnt++;
    if (vec(0) !== 5'b00100 || if_data[0] !== 32'h34011100)
      $display("FAIL post_reset_fetch: got vec=%b data=%h want 00100 34011100", vec(0), if_data[0]);
    else pass_cnt++;
    if_ce[0] = 0;
    tick;
    $display("reset_mid_busy: post-reset fetch data=%h", if_data[0]);
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_priority(1, 1'b1, '{5'b10001, 5'b00011, 5'b00001, 5'b10001, 5'b00100, 5'b00000});
    test_priority(2, 1'b0, '{5'b10001, 5'b00101, 5'b00001, 5'b10001, 5'b00010, 5'b00000});
    test_write;
    test_flush;
    test_reset_mid_busy;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
